// File: rtl/gpio_port_ctrl.sv
// Bidirectional GPIO port: per-bit direction/output registers, synchronised inputs,
// rising-edge capture (W1C) and maskable irq. Define GPIO_DEBOUNCE_EN for per-bit input debounce.
module gpio_port_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic             CLOCK_50,
    input  logic             Resetn,
    inout  wire  [WIDTH-1:0] GPIO,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             irq
);
    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_DIR  = 2'd1;
    localparam logic [1:0] A_EDGE = 2'd2;
    localparam logic [1:0] A_MASK = 2'd3;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_in_d;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_edge_clr;
    logic [WIDTH-1:0] w_rd_mux;

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || DEB_CYCLES < 2) begin : g_param_check
        $error("gpio_port_ctrl: parameter out of range");
    end

    // Drive is purely combinational from DIR/OUT so reset floats the pins at once.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign GPIO[i] = r_dir[i] ? r_out[i] : 1'bz;
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= GPIO;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_deb_cnt [WIDTH];
    logic [WIDTH-1:0] r_deb;

    // The counter's last step is the DEB_CYCLES-th clock of disagreement, where the new level is taken.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_deb <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync[SYNC_STAGES-1][i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == CNT_LAST) begin
                    r_deb[i]     <= r_sync[SYNC_STAGES-1][i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign w_in = r_deb;
`else
    assign w_in = r_sync[SYNC_STAGES-1];
`endif

    assign w_rise     = w_in & ~r_in_d;
    assign w_edge_clr = (wr_en && addr == A_EDGE) ? wr_data : '0;

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            A_DATA:  w_rd_mux = w_in;
            A_DIR:   w_rd_mux = r_dir;
            A_EDGE:  w_rd_mux = r_edge;
            A_MASK:  w_rd_mux = r_mask;
            default: w_rd_mux = '0;
        endcase
    end

    // A fresh rise is ORed in after the clear, so a colliding set always wins.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_out   <= '0;
            r_dir   <= '0;
            r_edge  <= '0;
            r_mask  <= '0;
            r_in_d  <= '0;
            rd_data <= '0;
            irq     <= 1'b0;
        end else begin
            r_in_d <= w_in;
            r_edge <= (r_edge & ~w_edge_clr) | w_rise;
            irq    <= |(r_edge & r_mask);
            if (wr_en) begin
                case (addr)
                    A_DATA:  r_out  <= wr_data;
                    A_DIR:   r_dir  <= wr_data;
                    A_MASK:  r_mask <= wr_data;
                    default: ;
                endcase
            end
            if (rd_en) begin
                rd_data <= w_rd_mux;
            end
        end
    end
endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Scoreboard bench for gpio_port_ctrl: stimulus queues expected reads/samples, a negedge monitor checks them.
module tb_gpio_port_ctrl;
    localparam int W   = 32;
    localparam int SS  = 2;
    localparam int DEB = 16;

    localparam int K_GPIO = 0;
    localparam int K_IRQ  = 1;
    localparam int K_RD   = 2;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] exp;
    } obs_t;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [1:0]    addr;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  rd_data;
    logic          irq;
    wire  [W-1:0]  gpio;
    logic [W-1:0]  tb_oe;
    logic [W-1:0]  tb_val;

    obs_t rd_q [$];
    obs_t obs_q [$];
    obs_t mon_e;
    logic rd_seen;
    logic end_req;
    int   n_checks;
    int   n_errors;

    for (genvar i = 0; i < W; i++) begin : g_tb_drv
        assign gpio[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    gpio_port_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .DEB_CYCLES(DEB)) dut (
        .CLOCK_50 (clk),
        .Resetn   (rst_n),
        .GPIO     (gpio),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected summary");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) rd_seen <= rd_en;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_read: got %h, expected no read", rd_data);
            end else begin
                mon_e = rd_q.pop_front();
                compare(mon_e.name, rd_data, mon_e.exp);
            end
        end
        while (obs_q.size() > 0) begin
            mon_e = obs_q.pop_front();
            case (mon_e.kind)
                K_GPIO:  compare(mon_e.name, gpio, mon_e.exp);
                K_IRQ:   compare(mon_e.name, {31'b0, irq}, mon_e.exp);
                default: compare(mon_e.name, rd_data, mon_e.exp);
            endcase
        end
        if (end_req) begin
            compare("queues_drained", 32'(rd_q.size() + obs_q.size()), 32'd0);
            $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
            $finish;
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wr_data = d;
        idle(1);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_en = 1'b1; addr = a;
        rd_q.push_back('{K_RD, name, exp});
        idle(1);
        rd_en = 1'b0;
    endtask

    task automatic wrrd(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
        wr_en = 1'b1; rd_en = 1'b1; addr = a; wr_data = d;
        rd_q.push_back('{K_RD, name, exp});
        idle(1);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic chk(input int kind, input logic [31:0] exp, input string name);
        obs_q.push_back('{kind, name, exp});
    endtask

    initial begin
        n_checks = 0; n_errors = 0; end_req = 1'b0; rd_seen = 1'b0;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; wr_data = '0;
        tb_oe = 32'hFFFF_0000; tb_val = 32'hEDCB_0000;
        idle(2);
        chk(K_IRQ, 32'd0, "por_irq");
        chk(K_RD, 32'd0, "por_rd_data");
        idle(1);
        rst_n = 1'b1;
        idle(1);

        // Output drive: lower half driven by the DUT, upper half by the bench.
        wr(2'd1, 32'h0000_FFFF);
        wr(2'd0, 32'h1234_5678);
        chk(K_GPIO, 32'hEDCB_5678, "drive_mixed");
        idle(SS);
        rd(2'd0, 32'hEDCB_5678, "readback_in");
        rd(2'd1, 32'h0000_FFFF, "read_dir");
        rd(2'd3, 32'h0000_0000, "read_mask");
        chk(K_IRQ, 32'd0, "irq_unmasked");
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'h0000_0000, "edge_cleared");

        // Bits 0, 3, 7 become bench-driven inputs held low.
        tb_oe = tb_oe | 32'h0000_0089;
        wr(2'd1, 32'h0000_FF76);
        idle(3);
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'h0000_0001);
        idle(2);

        // Edge and interrupt timing on bit 0.
        tb_val[0] = 1'b1;
        idle(SS);
        chk(K_IRQ, 32'd0, "irq_before_edge");
        idle(1);
        chk(K_IRQ, 32'd0, "irq_edge_cycle");
        idle(1);
        chk(K_IRQ, 32'd1, "irq_rise");
        rd(2'd2, 32'h0000_0001, "edge0_set");
        wr(2'd2, 32'h0000_0001);
        chk(K_IRQ, 32'd1, "irq_hold_after_clr");
        idle(1);
        chk(K_IRQ, 32'd0, "irq_drop_after_clr");

        // W1C collides with rise on bit 3.
        tb_val[3] = 1'b1;
        idle(SS);
        wr(2'd2, 32'h0000_0008);
        rd(2'd2, 32'h0000_0008, "collision_set_wins");
        wrrd(2'd3, 32'h0000_0000, 32'h0000_0001, "read_before_write");
        rd(2'd3, 32'h0000_0000, "mask_written");
        wr(2'd2, 32'h0000_0008);
        rd(2'd2, 32'h0000_0000, "edge3_cleared");

        // Masking on bit 7.
        tb_val[7] = 1'b1;
        idle(4);
        rd(2'd2, 32'h0000_0080, "edge7_set");
        chk(K_IRQ, 32'd0, "irq_masked_off");
        wr(2'd3, 32'h0000_0080);
        chk(K_IRQ, 32'd0, "irq_mask_lag");
        idle(1);
        chk(K_IRQ, 32'd1, "irq_mask_on");

        // Mid-run reset with every pin driven high by the DUT.
        tb_oe = '0;
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'hFFFF_FFFF);
        chk(K_GPIO, 32'hFFFF_FFFF, "drive_all_high");
        rd(2'd1, 32'hFFFF_FFFF, "read_dir_all");
        idle(1);
        rst_n = 1'b0;
        tb_oe = 32'hFFFF_FFFF;
        tb_val = 32'h0000_0000;
        chk(K_GPIO, 32'h0000_0000, "reset_pins_float");
        chk(K_IRQ, 32'd0, "reset_irq");
        chk(K_RD, 32'd0, "reset_rd_data");
        idle(1);
        rst_n = 1'b1;
        idle(1);
        rd(2'd1, 32'h0000_0000, "dir_after_reset");
        rd(2'd3, 32'h0000_0000, "mask_after_reset");
        rd(2'd2, 32'h0000_0000, "edge_after_reset");
        rd(2'd0, 32'h0000_0000, "in_after_reset");

`ifdef GPIO_DEBOUNCE_EN
        // Debounce on bit 5: short glitch rejected, long level accepted.
        wr(2'd3, 32'h0000_0020);
        tb_val[5] = 1'b1;
        idle(10);
        tb_val[5] = 1'b0;
        idle(20);
        chk(K_IRQ, 32'd0, "deb_glitch_irq");
        rd(2'd2, 32'h0000_0000, "deb_glitch_edge");
        tb_val[5] = 1'b1;
        idle(SS + DEB + 1);
        chk(K_IRQ, 32'd0, "deb_edge_cycle");
        idle(1);
        chk(K_IRQ, 32'd1, "deb_irq");
        rd(2'd2, 32'h0000_0020, "deb_edge5");
`endif

        idle(2);
        end_req = 1'b1;
        idle(2);
    end
endmodule
